// File: rtl/fifo4x16_pkg.sv
// Shared constants and types for the 4-entry, 16-bit FIFO and its read-port mux.
package fifo4x16_pkg;

  localparam int WORD_W     = 16;
  localparam int FIFO_DEPTH = 4;
  localparam int FIFO_PTR_W = 2;
  localparam int FIFO_CNT_W = 3;

  typedef logic [WORD_W-1:0]     word_t;
  typedef logic [FIFO_PTR_W-1:0] ptr_t;
  typedef logic [FIFO_CNT_W-1:0] cnt_t;

  localparam cnt_t CNT_EMPTY = '0;
  localparam cnt_t CNT_FULL  = cnt_t'(FIFO_DEPTH);

  // Occupancy view of the FIFO, derived from count only.
  typedef enum logic [1:0] {
    ST_EMPTY   = 2'd0,
    ST_PARTIAL = 2'd1,
    ST_FULL    = 2'd2
  } fill_state_e;

  // Pointers are exactly log2(DEPTH) wide, so the add wraps 3->0 on its own.
  function automatic ptr_t next_ptr(input ptr_t p);
    return p + ptr_t'(1);
  endfunction

endpackage

// File: rtl/fifo4x16_if.sv
// Producer/consumer bus of the FIFO; master is the environment, slave is the FIFO.
interface fifo4x16_if;
  import fifo4x16_pkg::*;

  // A word moves on a side only in a cycle where both valid and ready are 1 at
  // the rising edge; ready never depends combinationally on the other side's valid.
  logic        flush_i;
  logic        wr_valid_i;
  word_t       wr_data_i;
  logic        wr_ready_o;
  logic        rd_valid_o;
  word_t       rd_data_o;
  logic        rd_ready_i;
  cnt_t        count_o;
  fill_state_e state_o;

  modport master (
    output flush_i, wr_valid_i, wr_data_i, rd_ready_i,
    input  wr_ready_o, rd_valid_o, rd_data_o, count_o, state_o
  );

  modport slave (
    input  flush_i, wr_valid_i, wr_data_i, rd_ready_i,
    output wr_ready_o, rd_valid_o, rd_data_o, count_o, state_o
  );

endinterface

// File: rtl/fifo4x16_mux4way16.sv
// Mux4Way16: selects one of four 16-bit words by a 2-bit select.
module fifo4x16_mux4way16
  import fifo4x16_pkg::*;
(
  input  word_t a,
  input  word_t b,
  input  word_t c,
  input  word_t d,
  input  ptr_t  sel,
  output word_t out
);

  always_comb begin
    out = a;
    case (sel)
      2'd0: out = a;
      2'd1: out = b;
      2'd2: out = c;
      2'd3: out = d;
      default: out = a;
    endcase
  end

endmodule

// File: rtl/fifo4x16.sv
// 4-entry, 16-bit show-ahead FIFO; head word is read through a Mux4Way16 indexed by rd_ptr.
module fifo4x16
  import fifo4x16_pkg::*;
(
  input  logic        clk_i,
  input  logic        rst_n_i,
  fifo4x16_if.slave   bus
);

  word_t mem [FIFO_DEPTH];
  ptr_t  wr_ptr;
  ptr_t  rd_ptr;
  cnt_t  count;
  logic  push;
  logic  pop;

  assign bus.wr_ready_o = (count != CNT_FULL);
  assign bus.rd_valid_o = (count != CNT_EMPTY);
  assign bus.count_o    = count;

  assign push = bus.wr_valid_i & bus.wr_ready_o;
  assign pop  = bus.rd_valid_o & bus.rd_ready_i;

  always_comb begin
    bus.state_o = ST_PARTIAL;
    if (count == CNT_EMPTY)     bus.state_o = ST_EMPTY;
    else if (count == CNT_FULL) bus.state_o = ST_FULL;
  end

  fifo4x16_mux4way16 u_rd_mux (
    .a   (mem[0]),
    .b   (mem[1]),
    .c   (mem[2]),
    .d   (mem[3]),
    .sel (rd_ptr),
    .out (bus.rd_data_o)
  );

  // Flush rewinds pointers and count but leaves storage alone; rd_valid_o=0 hides it.
  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
      for (int i = 0; i < FIFO_DEPTH; i++) mem[i] <= '0;
    end else if (bus.flush_i) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) begin
        mem[wr_ptr] <= bus.wr_data_i;
        wr_ptr      <= next_ptr(wr_ptr);
      end
      if (pop) rd_ptr <= next_ptr(rd_ptr);
      case ({push, pop})
        2'b10:   count <= count + cnt_t'(1);
        2'b01:   count <= count - cnt_t'(1);
        default: count <= count;
      endcase
    end
  end

endmodule

// File: tb/tb_fifo4x16.sv
// Scoreboard bench for fifo4x16: a queue model predicts head data, flags and count every cycle.
module tb_fifo4x16;
  import fifo4x16_pkg::*;

  logic clk;
  logic rst_n;

  fifo4x16_if bus ();

  fifo4x16 dut (
    .clk_i   (clk),
    .rst_n_i (rst_n),
    .bus     (bus)
  );

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_checks = 0;
  int n_pass   = 0;
  logic [WORD_W-1:0] exp_q[$];

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0h, expected %0h (t=%0t)", tag, got, exp, $time);
  endtask

  function automatic fill_state_e exp_state(input int n);
    if (n == 0) return ST_EMPTY;
    if (n == FIFO_DEPTH) return ST_FULL;
    return ST_PARTIAL;
  endfunction

  // Compare every visible output against the model for the current cycle.
  task automatic check_outputs(input string tag);
    int n;
    n = exp_q.size();
    check({tag, ".wr_ready"}, 32'(bus.wr_ready_o), 32'(n != FIFO_DEPTH));
    check({tag, ".rd_valid"}, 32'(bus.rd_valid_o), 32'(n != 0));
    check({tag, ".count"},    32'(bus.count_o),    32'(n));
    check({tag, ".state"},    32'(bus.state_o),    32'(exp_state(n)));
    if (n != 0) check({tag, ".rd_data"}, 32'(bus.rd_data_o), 32'(exp_q[0]));
  endtask

  // driver: one clock cycle of stimulus, checked before the edge, model advanced after it
  task automatic cycle(input string tag, input logic wv, input logic [WORD_W-1:0] wd,
                       input logic rr, input logic fl);
    logic m_push, m_pop;
    bus.wr_valid_i = wv;
    bus.wr_data_i  = wd;
    bus.rd_ready_i = rr;
    bus.flush_i    = fl;
    #1;
    check_outputs(tag);
    m_push = wv && (exp_q.size() != FIFO_DEPTH);
    m_pop  = rr && (exp_q.size() != 0);
    if (fl) exp_q.delete();
    else begin
      if (m_pop) void'(exp_q.pop_front());
      if (m_push) exp_q.push_back(wd);
    end
    @(posedge clk);
    #1;
  endtask

  task automatic idle(input string tag);
    cycle(tag, 1'b0, 16'h0000, 1'b0, 1'b0);
  endtask

  initial begin
    rst_n          = 1'b0;
    bus.flush_i    = 1'b0;
    bus.wr_valid_i = 1'b0;
    bus.wr_data_i  = '0;
    bus.rd_ready_i = 1'b0;

    // reset held for two cycles
    repeat (2) @(posedge clk);
    #1;
    rst_n = 1'b1;
    #1;
    check("rst.wr_ready", 32'(bus.wr_ready_o), 32'd1);
    check("rst.rd_valid", 32'(bus.rd_valid_o), 32'd0);
    check("rst.count",    32'(bus.count_o),    32'd0);
    check("rst.rd_data",  32'(bus.rd_data_o),  32'h0000);

    // fill to full, then a rejected fifth push
    cycle("fill0", 1'b1, 16'h1111, 1'b0, 1'b0);
    cycle("fill1", 1'b1, 16'h2222, 1'b0, 1'b0);
    cycle("fill2", 1'b1, 16'h3333, 1'b0, 1'b0);
    cycle("fill3", 1'b1, 16'h4444, 1'b0, 1'b0);
    cycle("full_push", 1'b1, 16'hDEAD, 1'b0, 1'b0);
    check("full.count", 32'(bus.count_o), 32'd4);
    check("full.head",  32'(bus.rd_data_o), 32'h1111);

    // drain
    for (int i = 0; i < 4; i++) cycle("drain", 1'b0, 16'h0000, 1'b1, 1'b0);
    idle("drained");
    check("drained.rd_valid", 32'(bus.rd_valid_o), 32'd0);

    // preload two, then ten simultaneous push/pop cycles across pointer wrap
    cycle("pre0", 1'b1, 16'hA001, 1'b0, 1'b0);
    cycle("pre1", 1'b1, 16'hA002, 1'b0, 1'b0);
    for (int i = 1; i <= 10; i++) begin
      cycle("wrap", 1'b1, 16'(i), 1'b1, 1'b0);
      check("wrap.count", 32'(bus.count_o), 32'd2);
    end
    cycle("wrap_drain0", 1'b0, 16'h0000, 1'b1, 1'b0);
    cycle("wrap_drain1", 1'b0, 16'h0000, 1'b1, 1'b0);
    idle("wrap_empty");

    // full boundary: push+pop at count 4 pops only
    for (int i = 0; i < 4; i++) cycle("fb_fill", 1'b1, 16'hC000 + 16'(i), 1'b0, 1'b0);
    cycle("fb_both", 1'b1, 16'hCFFF, 1'b1, 1'b0);
    check("fb.count", 32'(bus.count_o), 32'd3);
    for (int i = 0; i < 3; i++) cycle("fb_drain", 1'b0, 16'h0000, 1'b1, 1'b0);

    // empty boundary: push+pop at count 0 pushes only
    cycle("eb_both", 1'b1, 16'h5A5A, 1'b1, 1'b0);
    check("eb.count", 32'(bus.count_o), 32'd1);
    check("eb.data",  32'(bus.rd_data_o), 32'h5A5A);
    cycle("eb_drain", 1'b0, 16'h0000, 1'b1, 1'b0);

    // flush priority over a same-cycle push
    for (int i = 0; i < 3; i++) cycle("fl_fill", 1'b1, 16'hE000 + 16'(i), 1'b0, 1'b0);
    cycle("flush", 1'b1, 16'hBEEF, 1'b0, 1'b1);
    check("flush.count",    32'(bus.count_o),    32'd0);
    check("flush.rd_valid", 32'(bus.rd_valid_o), 32'd0);
    cycle("post_flush", 1'b1, 16'h00AA, 1'b0, 1'b0);
    check("post_flush.data", 32'(bus.rd_data_o), 32'h00AA);
    cycle("post_flush_pop", 1'b0, 16'h0000, 1'b1, 1'b0);

    // random interleaving
    for (int i = 0; i < 300; i++)
      cycle("rand", 1'($urandom_range(0, 1)), 16'($urandom_range(0, 16'hFFFF)),
            1'($urandom_range(0, 1)), ($urandom_range(0, 31) == 0));
    for (int i = 0; i < 4; i++) cycle("rand_drain", 1'b0, 16'h0000, 1'b1, 1'b0);
    idle("rand_end");

    // asynchronous reset mid-stream at count 3, observed before any clock edge
    for (int i = 0; i < 3; i++) cycle("ar_fill", 1'b1, 16'h7000 + 16'(i), 1'b0, 1'b0);
    bus.wr_valid_i = 1'b0;
    check("ar.pre_count", 32'(bus.count_o), 32'd3);
    #1;
    rst_n = 1'b0;
    #1;
    check("ar.wr_ready", 32'(bus.wr_ready_o), 32'd1);
    check("ar.rd_valid", 32'(bus.rd_valid_o), 32'd0);
    check("ar.count",    32'(bus.count_o),    32'd0);
    check("ar.rd_data",  32'(bus.rd_data_o),  32'h0000);
    exp_q.delete();
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    cycle("ar_push", 1'b1, 16'h0BAD, 1'b0, 1'b0);
    cycle("ar_pop", 1'b0, 16'h0000, 1'b1, 1'b0);
    idle("final");

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/fifo4x16.md
Name: fifo4x16

Overview:
- 4-entry, 16-bit synchronous FIFO with valid/ready handshake on both sides.
- The storage registers feed a Mux4Way16 read port that is indexed by the read pointer.
- Sits directly upstream of the 4-way word selector. It buffers words from a producer (e.g. CPU out-port or ALU result stage) until the consumer accepts them.
- Read side is show-ahead: the head word is always visible on rd_data_o while rd_valid_o=1.

Parameters:
- DATA_W, 16, word width. Fixed to 16 to match the Mux4Way16 read port.
- DEPTH, 4, number of entries. Fixed to 4; pointers are 2 bits wide and wrap naturally.
- PTR_W, 2, pointer width, log2(DEPTH).

Ports:
- clk_i  input  1  single clock, rising edge.
- rst_n_i  input  1  reset, asynchronous assert, active-low.
- flush_i  input  1  synchronous clear of FIFO contents.
- wr_valid_i  input  1  producer has a word on wr_data_i.
- wr_data_i  input  16  word to enqueue.
- wr_ready_o  output  1  FIFO can accept a word this cycle.
- rd_valid_o  output  1  head word present on rd_data_o.
- rd_data_o  output  16  head word (show-ahead).
- rd_ready_i  input  1  consumer takes the head word this cycle.
- count_o  output  3  number of stored words, 0..4.

Behaviour:
- Reset (rst_n_i=0, asynchronous):
  - wr_ptr=0, rd_ptr=0, count=0.
  - All 4 storage words cleared to 16'h0000.
  - Outputs: wr_ready_o=1, rd_valid_o=0, count_o=0, rd_data_o=16'h0000.
  - Reset asserted mid-operation discards all contents immediately, with no clock required.
- Combinational outputs:
  - wr_ready_o = (count != 4).
  - rd_valid_o = (count != 0).
  - rd_data_o = mem[rd_ptr], selected through the Mux4Way16 instance with sel = rd_ptr.
  - wr_ready_o has no combinational dependence on rd_ready_i. rd_valid_o has no combinational dependence on wr_valid_i.
- Handshakes:
  - push = wr_valid_i & wr_ready_o.
  - pop = rd_valid_o & rd_ready_i.
- On the clock edge, when push: mem[wr_ptr] <= wr_data_i; wr_ptr <= wr_ptr+1 (mod 4).
- On the clock edge, when pop: rd_ptr <= rd_ptr+1 (mod 4).
- Count update:
  - push only: count+1.
  - pop only: count-1.
  - push and pop together: count unchanged.
- Latency: a word written into an empty FIFO appears on rd_data_o with rd_valid_o=1 in the cycle after the push edge. There is no same-cycle bypass.
- State view, derived from count:
  - EMPTY (0): push moves to PARTIAL; pop is impossible.
  - PARTIAL (1..3): push only increments; pop only decrements; push and pop together stay put; count 3 + push only goes to FULL.
  - FULL (4): wr_ready_o=0, so no push is possible even if rd_ready_i=1 that cycle; pop moves to PARTIAL with count 3.
- Wrap-around: pointers roll 3->0 silently. Full and empty are distinguished only by count, never by pointer equality.
- Ignored inputs:
  - wr_valid_i while full is ignored; the word is not written, and the producer must hold it.
  - rd_ready_i while empty is ignored.
- flush_i=1 at an edge:
  - Pointers and count go to 0.
  - Storage is not cleared, but rd_valid_o=0 hides it.
  - Flush has priority over a push or pop in the same cycle; that push or pop is dropped.
- Data ordering is strictly first-in-first-out. No word is duplicated or lost under any interleaving of push and pop.

Decomposition:
- Shared header of constants: WORD_W=16, FIFO_DEPTH=4, FIFO_PTR_W=2, FIFO_CNT_W=3.
- One sub-module: Mux4Way16 (existing), instanced once as the read-port selector. Its a/b/c/d inputs are mem[0..3] and its sel input is rd_ptr.
- Pointers, count and storage are kept in this module. No further sub-modules.

Test Plan:
- Reset check: hold rst_n_i=0 for 2 cycles, release -> wr_ready_o=1, rd_valid_o=0, count_o=0, rd_data_o=16'h0000. Assert rst_n_i=0 asynchronously mid-stream with count=3 -> outputs return to reset values without a clock edge.
- Fill to full: push 16'h1111, 16'h2222, 16'h3333, 16'h4444 on consecutive cycles with rd_ready_i=0 -> count_o reaches 4 and wr_ready_o=0; a 5th push of 16'hDEAD is not stored; rd_data_o=16'h1111.
- Drain: rd_ready_i=1 for 4 cycles -> rd_data_o sequence 1111, 2222, 3333, 4444; then rd_valid_o=0 and count_o=0.
- Wrap with simultaneous push and pop: preload 2 words, then push and pop together for 10 cycles with incrementing data 16'h0001.. -> count_o stays 2 throughout; output order is strictly FIFO across pointer wrap 3->0.
- Full boundary: when count=4, drive wr_valid_i=1 and rd_ready_i=1 together -> only the pop occurs and count_o=3 next cycle. When count=0, drive push and rd_ready_i=1 together -> count_o=1; the word is visible on rd_data_o next cycle.
- Flush priority: with count=3, assert flush_i together with a push of 16'hBEEF -> count_o=0 and rd_valid_o=0 next cycle. A following push of 16'h00AA appears at rd_data_o one cycle later.
